// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester handshakes, the response bus, the shared memory
// port and the mux select/busy status of the memory port arbiter.
//   master : arbiter side; takes requests, mem_ack and mem_rdata; drives the
//            readies, the response, the memory strobe/payload, sel and busy.
//   slave  : environment side (requesters plus memory); the mirror image.
interface mem_port_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_we;
    logic        req0_ready;

    logic        req1_valid;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_we;
    logic        req1_ready;

    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        sel;
    logic        busy;

    modport master (
        input  req0_valid, req0_addr, req0_wdata, req0_we,
        input  req1_valid, req1_addr, req1_wdata, req1_we,
        input  mem_ack, mem_rdata,
        output req0_ready, req1_ready, rsp_rdata, rsp_err,
        output mem_valid, mem_addr, mem_wdata, mem_we, sel, busy
    );

    modport slave (
        output req0_valid, req0_addr, req0_wdata, req0_we,
        output req1_valid, req1_addr, req1_wdata, req1_we,
        output mem_ack, mem_rdata,
        input  req0_ready, req1_ready, rsp_rdata, rsp_err,
        input  mem_valid, mem_addr, mem_wdata, mem_we, sel, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter and access sequencer for the CPU's shared 32-bit memory
// port. Requester 0 is instruction fetch, requester 1 is data load/store. One
// access is in flight at a time: IDLE -> ACCESS (until mem_ack or timeout)
// -> DONE (one-cycle ready pulse) -> IDLE.
// Parameters:
//   TIMEOUT : ACCESS cycles without mem_ack before abort (0 = never abort)
//   CW      : timeout counter width, TIMEOUT < 2**CW
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_port_arbiter_if.master (requests, response, memory port, sel, busy)
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    logic [1:0]    state;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          sel_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          grant_any;
    logic          grant_idx;

    // Round-robin pick: on a tie the requester not served last wins.
    // NOTE: every signal written in an always_comb gets a value on every path
    // (here via the if/else on every branch), otherwise a latch is inferred.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            grant_idx = ~last_grant;
        else
            grant_idx = bus.req1_valid;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            sel_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sel_q   <= grant_idx;
                        addr_q  <= grant_idx ? bus.req1_addr  : bus.req0_addr;
                        wdata_q <= grant_idx ? bus.req1_wdata : bus.req0_wdata;
                        we_q    <= grant_idx ? bus.req1_we    : bus.req0_we;
                        cnt     <= '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_ack is checked first so it wins over a coinciding timeout.
                    if (bus.mem_ack) begin
                        rdata_q <= bus.mem_rdata;
                        err_q   <= 1'b0;
                        state   <= DONE;
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    last_grant <= sel_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from the state register, so an asynchronous reset
    // removes mem_valid, busy and the readies without waiting for a clock.
    assign bus.mem_valid  = (state == ACCESS);
    assign bus.busy       = (state != IDLE);
    assign bus.req0_ready = (state == DONE) && !sel_q;
    assign bus.req1_ready = (state == DONE) &&  sel_q;

    assign bus.sel       = sel_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with TIMEOUT = 4. Each transaction is
// checked cycle by cycle: payload and sel on every ACCESS cycle, the single
// ready pulse and response in DONE, and a quiet IDLE cycle afterwards.
module tb_mem_port_arbiter;

    localparam int T = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(T), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction starting from an IDLE window where the request is
    // already presented. ack_at = ACCESS cycle (1-based) in which mem_ack is
    // raised; 0 means never, which must end in a timeout after T cycles.
    task automatic do_access(input string tag, input logic es, input logic [31:0] ea,
                             input logic [31:0] ew, input logic ewe,
                             input int ack_at, input logic [31:0] rd);
        int          n;
        logic        exp_err;
        logic [31:0] exp_rd;
        n       = (ack_at > 0) ? ack_at : T;
        exp_err = (ack_at == 0);
        exp_rd  = exp_err ? 32'h0 : rd;
        tick();
        for (int i = 0; i < n; i++) begin
            check({tag, "/acc_valid"}, 32'(bus.mem_valid), 32'd1);
            check({tag, "/acc_busy"},  32'(bus.busy),      32'd1);
            check({tag, "/acc_sel"},   32'(bus.sel),       32'(es));
            check({tag, "/acc_addr"},  bus.mem_addr,       ea);
            check({tag, "/acc_wdata"}, bus.mem_wdata,      ew);
            check({tag, "/acc_we"},    32'(bus.mem_we),    32'(ewe));
            check({tag, "/acc_rdy"},   32'({bus.req1_ready, bus.req0_ready}), 32'd0);
            if (ack_at > 0 && i == n - 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd;
            end
            tick();
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        check({tag, "/done_valid"}, 32'(bus.mem_valid), 32'd0);
        check({tag, "/done_busy"},  32'(bus.busy),      32'd1);
        check({tag, "/done_rdy"},   32'({bus.req1_ready, bus.req0_ready}),
              es ? 32'd2 : 32'd1);
        check({tag, "/done_err"},   32'(bus.rsp_err),   32'(exp_err));
        check({tag, "/done_rdata"}, bus.rsp_rdata,      exp_rd);
        check({tag, "/done_sel"},   32'(bus.sel),       32'(es));
        tick();
        check({tag, "/idle_rdy"},   32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        check({tag, "/idle_busy"},  32'(bus.busy),      32'd0);
        check({tag, "/idle_sel"},   32'(bus.sel),       32'(es));
    endtask

    task automatic set_req(input logic idx, input logic v, input logic [31:0] a,
                           input logic [31:0] w, input logic we);
        if (idx) begin
            bus.req1_valid = v; bus.req1_addr = a; bus.req1_wdata = w; bus.req1_we = we;
        end else begin
            bus.req0_valid = v; bus.req0_addr = a; bus.req0_wdata = w; bus.req0_we = we;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/valid"}, 32'(bus.mem_valid), 32'd0);
        check({tag, "/busy"},  32'(bus.busy),      32'd0);
        check({tag, "/rdy"},   32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        check({tag, "/sel"},   32'(bus.sel),       32'd0);
        check({tag, "/addr"},  bus.mem_addr,       32'd0);
        check({tag, "/wdata"}, bus.mem_wdata,      32'd0);
        check({tag, "/we"},    32'(bus.mem_we),    32'd0);
        check({tag, "/rdata"}, bus.rsp_rdata,      32'd0);
        check({tag, "/err"},   32'(bus.rsp_err),   32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        // Asynchronous reset between edges: outputs clear without a clock.
        #3 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        tick();
        tick();
        #4 rst = 1'b0;   // released on a falling edge, IDLE window follows

        // Contention: first tie after reset goes to requester 0, then alternates.
        set_req(1'b0, 1'b1, 32'h0000_0200, 32'h0000_0A00, 1'b0);
        set_req(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0B00, 1'b1);
        do_access("tie0", 1'b0, 32'h0000_0200, 32'h0000_0A00, 1'b0, 1, 32'h1111_0000);
        do_access("tie1", 1'b1, 32'h0000_0300, 32'h0000_0B00, 1'b1, 1, 32'h2222_0000);
        do_access("tie2", 1'b0, 32'h0000_0200, 32'h0000_0A00, 1'b0, 1, 32'h3333_0000);
        do_access("tie3", 1'b1, 32'h0000_0300, 32'h0000_0B00, 1'b1, 1, 32'h4444_0000);
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // An IDLE cycle with no request must not start an access.
        tick();
        check("no_req/busy", 32'(bus.busy), 32'd0);

        // Single read with two wait cycles (ack in the 3rd ACCESS cycle).
        set_req(1'b0, 1'b1, 32'h0000_0040, 32'h0, 1'b0);
        do_access("read", 1'b0, 32'h0000_0040, 32'h0, 1'b0, 3, 32'h1234_5678);
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Zero-wait write from requester 1.
        set_req(1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 1'b1);
        do_access("write", 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 1'b1, 1, 32'hDEAD_BEEF);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Timeout: no ack, mem_valid for exactly T cycles, err with zero data.
        set_req(1'b0, 1'b1, 32'h0000_0080, 32'h0, 1'b0);
        do_access("timeout", 1'b0, 32'h0000_0080, 32'h0, 1'b0, 0, 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Ack together with the final count: ack wins, no error.
        set_req(1'b1, 1'b1, 32'h0000_00C0, 32'h0, 1'b0);
        do_access("ack_last", 1'b1, 32'h0000_00C0, 32'h0, 1'b0, T, 32'hCAFE_F00D);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset during the 2nd ACCESS cycle, then the request is re-presented.
        set_req(1'b1, 1'b1, 32'h0000_0044, 32'h5555_0000, 1'b1);
        tick();
        check("mid/acc1_valid", 32'(bus.mem_valid), 32'd1);
        check("mid/acc1_sel",   32'(bus.sel),       32'd1);
        tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        #1 rst = 1'b0;
        do_access("re_req", 1'b1, 32'h0000_0044, 32'h5555_0000, 1'b1, 2, 32'h0BAD_0001);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the shared 32-bit memory port of the CPU. It accepts requests from requester 0 (instruction fetch) and requester 1 (data load/store) and grants them round-robin. It drives the select line of the port's 32-bit 2:1 operand/address mux and runs a multi-cycle access with acknowledge and timeout. Only one access is in flight at a time.

## Interface

Parameters:
- TIMEOUT, 255: maximum ACCESS cycles without `mem_ack` before abort; 0 disables the timeout.
- CW, 8: timeout counter width; must satisfy TIMEOUT < 2^CW.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 request; held with payload until `req0_ready`.
- req0_addr  in  32  requester 0 address.
- req0_wdata  in  32  requester 0 write data.
- req0_we  in  1  requester 0 write enable.
- req0_ready  out  1  one-cycle completion pulse to requester 0.
- req1_valid, req1_addr, req1_wdata, req1_we, req1_ready: same as requester 0, for requester 1.
- rsp_rdata  out  32  read data; valid while any `reqN_ready` is 1.
- rsp_err  out  1  timeout flag; valid while any `reqN_ready` is 1.
- mem_valid  out  1  access strobe to memory.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched write data.
- mem_we  out  1  latched write enable.
- mem_ack  in  1  memory completion; sampled only in ACCESS.
- mem_rdata  in  32  memory read data; sampled when `mem_ack` is 1.
- sel  out  1  mux select: 0 = requester 0, 1 = requester 1.
- busy  out  1  1 in ACCESS or DONE.

## Operation

- FSM states: IDLE, ACCESS, DONE. All outputs are registered or decoded from state.
- IDLE:
  - No valid request: stay in IDLE.
  - One valid request: grant that requester.
  - Both valid: grant the requester that was not served last (`last_grant`).
  - On grant: latch addr, wdata and we into the `mem_*` registers; set `sel` to the granted index; clear the counter; go to ACCESS.
- ACCESS:
  - `mem_valid` = 1; `mem_addr`, `mem_wdata`, `mem_we` and `sel` are stable.
  - Request inputs are ignored; changes on them do not affect the access in flight.
  - `mem_ack` = 1: capture `mem_rdata` into `rsp_rdata`; `rsp_err` = 0; go to DONE.
  - Otherwise, when TIMEOUT ≠ 0 and the counter reaches TIMEOUT-1: `rsp_rdata` = 0; `rsp_err` = 1; go to DONE.
  - Otherwise: increment the counter.
  - If `mem_ack` and the timeout coincide, `mem_ack` wins.
- DONE:
  - `req<sel>_ready` = 1 for exactly one cycle; the other ready stays 0.
  - `last_grant` is set to `sel`.
  - Always go to IDLE next.
  - The requester treats the edge where ready = 1 as the transfer. Valid seen in the following IDLE cycle is a new request.
- `sel` holds its value in IDLE and DONE. It changes only on a grant.
- Writes: `rsp_rdata` carries `mem_rdata` as sampled. Requesters ignore it.
- Reset values:
  - State IDLE; `last_grant` = 1, so requester 0 wins the first tie.
  - `sel`, `mem_valid`, `mem_we`, `req0_ready`, `req1_ready`, `rsp_err`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, `rsp_rdata` = 0; counter = 0.
- Reset mid-operation: asynchronous return to reset values. `mem_valid` drops without waiting for a clock. The aborted requester gets no ready pulse and must re-present its request.

## Timing

- A request sampled in IDLE at edge k puts `mem_valid` = 1 from edge k+1.
- `mem_ack` first sampled at edge k+1+n (n ≥ 0 wait cycles) gives DONE, i.e. ready = 1, from edge k+2+n for one cycle. IDLE follows at edge k+3+n.
- Minimum occupancy is 3 cycles per transaction, giving peak throughput of one access per 3 cycles.
- Timeout: with TIMEOUT = T and no `mem_ack`, `mem_valid` stays high for exactly T cycles, then DONE with `rsp_err` = 1.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1. Worst-case wait is one full transaction of the other requester.

## Test plan

- Reset: assert `rst` asynchronously between edges -> all outputs 0 immediately; first post-reset tie grants requester 0.
- Single read: `req0_valid`=1, addr 0x0000_0040; `mem_ack` after 2 wait cycles with `mem_rdata`=0x1234_5678 -> `mem_addr`=0x40 and `sel`=0 for 3 ACCESS cycles; `req0_ready` pulses 1 cycle; `rsp_rdata`=0x1234_5678; `rsp_err`=0.
- Write: `req1` addr 0x0000_0100, wdata 0xA5A5_A5A5, we=1; zero-wait ack -> `sel`=1; `mem_we`=1 and `mem_wdata`=0xA5A5_A5A5 for 1 ACCESS cycle; `req1_ready` pulses 1 cycle.
- Contention: both valid continuously for 4 transactions, zero-wait ack -> grant order 0,1,0,1; each transaction exactly 3 cycles; no double ready.
- Timeout: TIMEOUT=4, no `mem_ack` -> `mem_valid` high exactly 4 cycles; ready pulse with `rsp_err`=1 and `rsp_rdata`=0. Ack arriving together with the final count -> `rsp_err`=0.
- Reset mid-ACCESS: assert `rst` during the 2nd ACCESS cycle -> `mem_valid` 0 at once; no ready; after release the re-presented request completes normally.
